// File: rtl/sw_control.sv
// sw_control: sequencing controller for the stopwatch counter/display datapath.
// Conditions the raw user inputs, runs the RUN/PAUSED/ADJUST mode machine and
// produces every timing pulse the datapath consumes.
//
// Ports:
//   clk       system clock
//   RESET     asynchronous, active-high reset
//   PAUSE     raw pause pushbutton (synchronized + debounced)
//   ADJ       raw adjust-mode switch (synchronized)
//   SEL       raw field select, 0 = minutes, 1 = seconds (synchronized)
//   sec_en    one-cycle pulse: increment seconds field
//   min_en    one-cycle pulse: increment minutes field (ADJUST only)
//   adj_mode  high while in ADJUST
//   blink     blanking phase for the selected field in ADJUST
//   scan_en   one-cycle pulse: advance display digit
//   scan_idx  current display digit, 0..3
//   paused    pause flag
//   cnt_clr   one-cycle pulse: clear datapath counters
//
// Optional feature macro: SW_LONGPRESS_CLR_EN (long PAUSE press clears the
// counters). When undefined, cnt_clr is constant 0 and LONG_CYCLES is unused.
module sw_control #(
  parameter int unsigned DIV_1HZ     = 100000000,
  parameter int unsigned DIV_2HZ     = 50000000,
  parameter int unsigned DIV_SCAN    = 100000,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned LONG_CYCLES = 200000000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic       sec_en,
  output logic       min_en,
  output logic       adj_mode,
  output logic       blink,
  output logic       scan_en,
  output logic [1:0] scan_idx,
  output logic       paused,
  output logic       cnt_clr
);

  localparam int unsigned C1_W = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
  localparam int unsigned C2_W = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
  localparam int unsigned CS_W = (DIV_SCAN  > 1) ? $clog2(DIV_SCAN)  : 1;
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_ADJUST  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        pause_sync, adj_sync, sel_sync;
  logic              pause_s, adj_s, sel_s;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic              pause_rise_c;
  logic              long_clr_c;
  logic              paused_nx;
  logic [C1_W-1:0]   cnt1, cnt1_nx;
  logic [C2_W-1:0]   cnt2, cnt2_nx;
  logic [CS_W-1:0]   cnts;
  logic              run_stay_c, adj_stay_c, wrap1_c, wrap2_c, wraps_c;

  assign pause_s = pause_sync[1];
  assign adj_s   = adj_sync[1];
  assign sel_s   = sel_sync[1];

  // 2-FF synchronizers for all three raw inputs
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pause_sync <= '0;
      adj_sync   <= '0;
      sel_sync   <= '0;
    end else begin
      pause_sync <= {pause_sync[0], PAUSE};
      adj_sync   <= {adj_sync[0], ADJ};
      sel_sync   <= {sel_sync[0], SEL};
    end
  end

  // Debouncer: level follows the synced input only after DB_CYCLES
  // consecutive differing cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (pause_s != db_level) begin
      if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        db_level <= pause_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Rising edge of the debounced level, aligned with the edge that sets it
  assign pause_rise_c = pause_s & ~db_level & (db_cnt == DB_W'(DB_CYCLES - 1));

`ifdef SW_LONGPRESS_CLR_EN
  localparam int unsigned LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  logic [LONG_W-1:0] long_cnt;
  logic              long_done;

  assign long_clr_c = db_level & ~long_done & (long_cnt == LONG_W'(LONG_CYCLES - 1));

  // Long-press timer: fires once per press, re-arms on release
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
    end else if (!db_level) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
    end else if (!long_done) begin
      if (long_clr_c) begin
        long_cnt  <= '0;
        long_done <= 1'b1;
      end else begin
        long_cnt <= long_cnt + LONG_W'(1);
      end
    end
  end
`else
  logic unused_long;

  assign long_clr_c  = 1'b0;
  assign unused_long = (LONG_CYCLES == 32'd0);
`endif

  // State register and pause flag
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= ST_RUN;
      paused <= 1'b0;
    end else begin
      state  <= state_nx;
      paused <= paused_nx;
    end
  end

  // Next state, pause flag and divider next values
  always_comb begin
    paused_nx  = paused;
    state_nx   = state;
    run_stay_c = 1'b0;
    adj_stay_c = 1'b0;
    wrap1_c    = 1'b0;
    wrap2_c    = 1'b0;
    cnt1_nx    = '0;
    cnt2_nx    = '0;

    // Forced clear overrides the toggle from the same press
    if (long_clr_c) begin
      paused_nx = 1'b0;
    end else if (pause_rise_c) begin
      paused_nx = ~paused;
    end

    case (state)
      ST_RUN:    if (paused_nx)  state_nx = ST_PAUSED;
      ST_PAUSED: if (!paused_nx) state_nx = ST_RUN;
      ST_ADJUST: state_nx = paused_nx ? ST_PAUSED : ST_RUN;
      default:   state_nx = ST_RUN;
    endcase

    // ADJ wins over any simultaneous pause event
    if (adj_s) state_nx = ST_ADJUST;

    // Dividers only count while staying in their mode, so leaving a mode
    // discards the partial period and entering one starts from zero.
    run_stay_c = (state == ST_RUN) && (state_nx == ST_RUN);
    adj_stay_c = (state == ST_ADJUST) && (state_nx == ST_ADJUST);
    wrap1_c    = run_stay_c && (cnt1 == C1_W'(DIV_1HZ - 1));
    wrap2_c    = adj_stay_c && (cnt2 == C2_W'(DIV_2HZ - 1));

    if (run_stay_c && !wrap1_c) cnt1_nx = cnt1 + C1_W'(1);
    if (adj_stay_c && !wrap2_c) cnt2_nx = cnt2 + C2_W'(1);
  end

  assign wraps_c = (cnts == CS_W'(DIV_SCAN - 1));

  // Dividers and registered outputs
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cnt1     <= '0;
      cnt2     <= '0;
      cnts     <= '0;
      sec_en   <= 1'b0;
      min_en   <= 1'b0;
      adj_mode <= 1'b0;
      blink    <= 1'b0;
      scan_en  <= 1'b0;
      scan_idx <= 2'd0;
      cnt_clr  <= 1'b0;
    end else begin
      cnt1     <= cnt1_nx;
      cnt2     <= cnt2_nx;
      cnts     <= wraps_c ? '0 : cnts + CS_W'(1);
      sec_en   <= wrap1_c | (wrap2_c & sel_s);
      min_en   <= wrap2_c & ~sel_s;
      adj_mode <= (state_nx == ST_ADJUST);
      blink    <= (state_nx == ST_ADJUST) && (cnt2_nx < C2_W'(DIV_2HZ / 2));
      scan_en  <= wraps_c;
      if (wraps_c) scan_idx <= scan_idx + 2'd1;
      cnt_clr  <= long_clr_c;
    end
  end

endmodule
